fir_out_quant: RTL and testbench

Downstream stage of the 64-tap FIR core. It consumes the 41-bit signed accumulator result and the `valid_out` level from the core. Each result is captured once per output event, rounded, right-shifted to the output Q format and saturated to 16 bits. The result is buffered in a small FIFO and presented on a valid/ready stream to the next block (DAC/serialiser).
- Sticky status flags report saturation and dropped samples.

---
 rtl/fir_pkg.sv | 36 +++
 rtl/fir_out_quant_if.sv | 12 +
 rtl/fir_out_fifo.sv | 67 ++++++
 rtl/fir_out_quant.sv | 93 +++++++++
 tb/tb_fir_out_quant.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Constants shared with the 64-tap FIR core and the output saturation helper.
// sat_to_out clamps a rounded, shifted accumulator value to the signed output range.
`timescale 1ns/1ps
package fir_pkg;

    localparam int FIR_DIN_W     = 41;
    localparam int FIR_OUT_W     = 16;
    localparam int FIR_Q_SHIFT   = 15;
    localparam int FIR_OUT_DEPTH = 4;
    localparam int FIR_ACC_W     = FIR_DIN_W + 1;

    localparam logic signed [FIR_ACC_W-1:0] FIR_OUT_MAX =
        FIR_ACC_W'((64'sd1 <<< (FIR_OUT_W - 1)) - 64'sd1);
    localparam logic signed [FIR_ACC_W-1:0] FIR_OUT_MIN =
        FIR_ACC_W'(-(64'sd1 <<< (FIR_OUT_W - 1)));

    typedef struct packed {
        logic                        clamped;
        logic signed [FIR_OUT_W-1:0] value;
    } sat_t;

    function automatic sat_t sat_to_out(input logic signed [FIR_ACC_W-1:0] q);
        sat_t res;
        res.clamped = 1'b1;
        if (q > FIR_OUT_MAX) begin
            res.value = FIR_OUT_MAX[FIR_OUT_W-1:0];
        end else if (q < FIR_OUT_MIN) begin
            res.value = FIR_OUT_MIN[FIR_OUT_W-1:0];
        end else begin
            res.clamped = 1'b0;
            res.value   = q[FIR_OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_out_quant_if.sv
// Valid/ready sample stream from the quantiser to the DAC/serialiser.
`timescale 1ns/1ps
interface fir_out_quant_if #(
    parameter int OUT_W = 16
) ();
    logic signed [OUT_W-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO; the head is visible on rd_data_o while not empty.
// When empty, rd_data_o keeps the last head that was presented.
`timescale 1ns/1ps
module fir_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] last_q;
    logic             wr_en, rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || pop_i);

    assign rd_data_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: default first, so no path through this block leaves count_d unassigned (latch).
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            count_q <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (!empty_o) last_q <= mem_q[rd_ptr_q];
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after the pointers say it was written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/fir_out_quant.sv
// FIR output quantiser: one capture per rising fir_valid, round, shift, saturate,
// then buffer the sample in a show-ahead FIFO driving a valid/ready stream.
`timescale 1ns/1ps
module fir_out_quant
    import fir_pkg::*;
#(
    parameter int DIN_W = FIR_DIN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = FIR_Q_SHIFT,
    parameter int DEPTH = FIR_OUT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic signed [DIN_W-1:0]  fir_dout,
    input  logic                     fir_valid,
    input  logic                     clr_flags,
    output logic                     sat_flag,
    output logic                     drop_flag,
    output logic [$clog2(DEPTH):0]   fifo_count,
    fir_out_quant_if.master          strm
);

    localparam int ACC_W = DIN_W + 1;
    localparam logic [ACC_W-1:0]        RND_ONE = 1;
    localparam logic signed [ACC_W-1:0] RND     = $signed((RND_ONE << SHIFT) >> 1);

    logic                    fir_valid_q;
    logic                    cap_evt;
    logic                    s1_valid_q;
    logic signed [ACC_W-1:0] s1_q, s1_d;
    logic                    s2_valid_q;
    logic [OUT_W-1:0]        s2_data_q;
    sat_t                    sat_s;
    logic                    sat_flag_q, sat_flag_d;
    logic                    drop_flag_q, drop_flag_d;
    logic                    fifo_full, fifo_empty, pop;
    logic [OUT_W-1:0]        fifo_rd_data;

    assign cap_evt = fir_valid && !fir_valid_q;
    assign pop     = !fifo_empty && strm.m_ready;

    always_comb begin
        // The extra accumulator bit keeps the rounding add from wrapping at full-scale positive.
        s1_d  = ($signed({fir_dout[DIN_W-1], fir_dout}) + RND) >>> SHIFT;
        sat_s = sat_to_out(FIR_ACC_W'(s1_q));
        // A set condition on the clearing edge wins.
        sat_flag_d  = (sat_flag_q && !clr_flags) || (s1_valid_q && sat_s.clamped);
        drop_flag_d = (drop_flag_q && !clr_flags) || (s2_valid_q && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values.
        if (!rstn) begin
            fir_valid_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            sat_flag_q  <= 1'b0;
            drop_flag_q <= 1'b0;
        end else begin
            fir_valid_q <= fir_valid;
            s1_valid_q  <= cap_evt;
            s2_valid_q  <= s1_valid_q;
            sat_flag_q  <= sat_flag_d;
            drop_flag_q <= drop_flag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_evt)    s1_q      <= s1_d;
        if (s1_valid_q) s2_data_q <= sat_s.value;
    end

    fir_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (s2_valid_q),
        .wr_data_i (s2_data_q),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign strm.m_data  = fifo_rd_data;
    assign strm.m_valid = !fifo_empty;
    assign sat_flag     = sat_flag_q;
    assign drop_flag    = drop_flag_q;

endmodule

// File: tb/tb_fir_out_quant.sv
// Self-checking bench for fir_out_quant: directed scenarios plus randomized traffic
// compared with a real-arithmetic rounding/saturation model and an expected-sample queue.
`timescale 1ns/1ps
module tb_fir_out_quant;

    localparam int DIN_W = 41;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic signed [DIN_W-1:0] fir_dout = '0;
    logic                    fir_valid = 1'b0;
    logic                    clr_flags = 1'b0;
    logic                    sat_flag, drop_flag;
    logic [CNT_W-1:0]        fifo_count;

    int checks = 0;
    int errors = 0;

    fir_out_quant_if #(.OUT_W(OUT_W)) strm ();

    fir_out_quant #(
        .DIN_W (DIN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fir_dout   (fir_dout),
        .fir_valid  (fir_valid),
        .clr_flags  (clr_flags),
        .sat_flag   (sat_flag),
        .drop_flag  (drop_flag),
        .fifo_count (fifo_count),
        .strm       (strm)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Round half toward +inf of x / 2^SHIFT, computed in real arithmetic.
    function automatic longint ref_round(input longint x);
        real scale;
        scale = real'(longint'(1) << SHIFT);
        return longint'($floor(real'(x) / scale + 0.5));
    endfunction

    function automatic longint ref_sample(input longint x);
        longint q, lim;
        q   = ref_round(x);
        lim = longint'(1) << (OUT_W - 1);
        if (q > lim - 1) return lim - 1;
        if (q < -lim)    return -lim;
        return q;
    endfunction

    function automatic bit ref_clamped(input longint x);
        return ref_sample(x) != ref_round(x);
    endfunction

    function automatic longint rand_small();
        return longint'($urandom_range(0, 32'h3fff_ffff)) - 64'sd536870912;
    endfunction

    function automatic longint rand_full();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return longint'($signed(w[DIN_W-1:0]));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_event(input longint x);
        fir_dout  = DIN_W'(x);
        fir_valid = 1'b1;
        tick();
        fir_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    // One event into an empty FIFO with m_ready=1; reports whether m_valid rose exactly two edges later.
    task automatic run_single(input longint x, output bit lat_ok, output longint got);
        pulse_event(x);
        lat_ok = !strm.m_valid;
        tick();
        lat_ok = lat_ok && !strm.m_valid;
        tick();
        lat_ok = lat_ok && strm.m_valid;
        got = longint'(strm.m_data);
        tick();
    endtask

    task automatic wait_count(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (int'(fifo_count) == n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        strm.m_ready = 1'b0;
        tick();
        tick();
        checks++; if (strm.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", strm.m_valid); end
        checks++; if (strm.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0d expected 0", strm.m_data); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (sat_flag !== 1'b0 || drop_flag !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got sat=%b drop=%b expected 0 0", sat_flag, drop_flag);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_rounding();
        longint vals [4] = '{64'sd16384, 64'sd16383, -64'sd16384, -64'sd16385};
        longint exps [4] = '{64'sd1, 64'sd0, 64'sd0, -64'sd1};
        bit     lat_ok;
        longint got, x;
        strm.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            longint exp_v;
            if (i < 4) begin x = vals[i]; exp_v = exps[i]; end
            else begin x = rand_small(); exp_v = ref_sample(x); end
            run_single(x, lat_ok, got);
            checks++; if (!lat_ok) begin errors++; $display("FAIL round_latency[%0d]: m_valid not 0,0,1 after event for x=%0d", i, x); end
            checks++; if (got !== exp_v) begin errors++; $display("FAIL round_value[%0d]: x=%0d got %0d expected %0d", i, x, got, exp_v); end
        end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL round_no_sat: got sat_flag=%b expected 0", sat_flag); end
    endtask

    task automatic test_saturation();
        bit     lat_ok, exp_sat;
        longint got, x;
        strm.m_ready = 1'b1;
        run_single(64'sd2147483648, lat_ok, got);
        checks++; if (got !== 64'sd32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", got); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b expected 1", sat_flag); end
        run_single(-64'sd2147483648, lat_ok, got);
        checks++; if (got !== -64'sd32768) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", got); end
        pulse_clear();
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b expected 0", sat_flag); end
        // Clamp reaches stage 2 on the same edge as the clear pulse.
        pulse_event(64'sd2147483648);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_set_wins: got %b expected 1", sat_flag); end
        tick();
        tick();
        pulse_clear();
        exp_sat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x = rand_full();
            exp_sat = exp_sat || ref_clamped(x);
            run_single(x, lat_ok, got);
            checks++; if (got !== ref_sample(x)) begin errors++; $display("FAIL sat_rand[%0d]: x=%0d got %0d expected %0d", i, x, got, ref_sample(x)); end
        end
        checks++; if (sat_flag !== exp_sat) begin errors++; $display("FAIL sat_rand_flag: got %b expected %b", sat_flag, exp_sat); end
    endtask

    task automatic test_edge_detect();
        longint v0;
        strm.m_ready = 1'b0;
        v0 = rand_small();
        fir_dout  = DIN_W'(v0);
        fir_valid = 1'b1;
        tick();
        for (int i = 0; i < 49; i++) begin
            fir_dout = DIN_W'(rand_small());
            tick();
        end
        fir_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (fifo_count !== CNT_W'(1)) begin errors++; $display("FAIL edge_count: got %0d expected 1", fifo_count); end
        checks++; if (!strm.m_valid || longint'(strm.m_data) !== ref_sample(v0)) begin
            errors++; $display("FAIL edge_value: got valid=%b data=%0d expected 1 %0d", strm.m_valid, strm.m_data, ref_sample(v0));
        end
        strm.m_ready = 1'b1;
        tick();
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL edge_drain: got count %0d expected 0", fifo_count); end
    endtask

    task automatic test_overflow();
        pulse_clear();
        strm.m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            pulse_event(longint'(k) * 32768);
            tick();
        end
        tick(); tick(); tick();
        checks++; if (fifo_count !== CNT_W'(4)) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL ovf_drop: got %b expected 1", drop_flag); end
        strm.m_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (!strm.m_valid || longint'(strm.m_data) !== longint'(k)) begin
                errors++; $display("FAIL ovf_drain[%0d]: got valid=%b data=%0d expected 1 %0d", k, strm.m_valid, strm.m_data, k);
            end
            tick();
        end
        checks++; if (strm.m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got m_valid=%b expected 0", strm.m_valid); end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        pulse_clear();
        strm.m_ready = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            pulse_event(longint'(k) * 32768);
            tick();
        end
        wait_count(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fpp_fill: got count %0d expected 4 within budget", fifo_count); end
        pulse_event(64'sd14 * 32768);
        tick();
        strm.m_ready = 1'b1;
        tick();
        strm.m_ready = 1'b0;
        checks++; if (fifo_count !== CNT_W'(4)) begin errors++; $display("FAIL fpp_count: got %0d expected 4", fifo_count); end
        checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL fpp_drop: got %b expected 0", drop_flag); end
        strm.m_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            checks++; if (!strm.m_valid || longint'(strm.m_data) !== longint'(k)) begin
                errors++; $display("FAIL fpp_drain[%0d]: got valid=%b data=%0d expected 1 %0d", k, strm.m_valid, strm.m_data, k);
            end
            tick();
        end
        checks++; if (strm.m_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got m_valid=%b expected 0", strm.m_valid); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        pulse_clear();
        strm.m_ready = 1'b0;
        pulse_event(64'sd2147483648); tick();
        pulse_event(64'sd3 * 32768);  tick();
        pulse_event(64'sd5 * 32768);  tick();
        wait_count(3, ok);
        checks++; if (!ok || sat_flag !== 1'b1) begin
            errors++; $display("FAIL rstmid_setup: got count=%0d sat=%b expected 3 1", fifo_count, sat_flag);
        end
        pulse_event(64'sd7 * 32768);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (strm.m_valid !== 1'b0 || fifo_count !== '0) begin
            errors++; $display("FAIL rstmid_state: got valid=%b count=%0d expected 0 0", strm.m_valid, fifo_count);
        end
        checks++; if (sat_flag !== 1'b0 || drop_flag !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags: got sat=%b drop=%b expected 0 0", sat_flag, drop_flag);
        end
        strm.m_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen || strm.m_valid;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got a sample after reset expected none"); end
    endtask

    task automatic test_reset_release();
        strm.m_ready = 1'b1;
        fir_dout  = DIN_W'(64'sd9 * 32768);
        fir_valid = 1'b1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        fir_valid = 1'b0;
        checks++; if (strm.m_valid !== 1'b0) begin errors++; $display("FAIL rel_early: got m_valid=%b expected 0", strm.m_valid); end
        tick();
        tick();
        checks++; if (!strm.m_valid || strm.m_data !== 16'sd9) begin
            errors++; $display("FAIL rel_event: got valid=%b data=%0d expected 1 9", strm.m_valid, strm.m_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        longint expq [$];
        longint x, held;
        bit     hold, exp_sat;
        pulse_clear();
        hold = 1'b0;
        held = 0;
        exp_sat = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            fir_valid = (cyc % 2 == 0) && (cyc < 70);
            if (fir_valid) begin
                x = ($urandom_range(0, 1) == 0) ? rand_small() : rand_full();
                fir_dout = DIN_W'(x);
                expq.push_back(ref_sample(x));
                exp_sat = exp_sat || ref_clamped(x);
            end
            strm.m_ready = (cyc % 3 != 2);
            if (hold) begin
                checks++; if (!strm.m_valid || longint'(strm.m_data) !== held) begin
                    errors++; $display("FAIL b2b_stable[%0d]: got valid=%b data=%0d expected 1 %0d", cyc, strm.m_valid, strm.m_data, held);
                end
            end
            if (strm.m_valid && strm.m_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_extra[%0d]: got data=%0d expected no sample", cyc, strm.m_data);
                end else if (longint'(strm.m_data) !== expq[0]) begin
                    errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", cyc, strm.m_data, expq[0]);
                    void'(expq.pop_front());
                end else begin
                    void'(expq.pop_front());
                end
            end
            hold = strm.m_valid && !strm.m_ready;
            held = longint'(strm.m_data);
            tick();
        end
        fir_valid = 1'b0;
        checks++; if (expq.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d undelivered expected 0", expq.size()); end
        checks++; if (drop_flag !== 1'b0 || sat_flag !== exp_sat) begin
            errors++; $display("FAIL b2b_flags: got sat=%b drop=%b expected %b 0", sat_flag, drop_flag, exp_sat);
        end
    endtask

    initial begin
        strm.m_ready = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_edge_detect();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_reset_release();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
